complex_accumulator: RTL and testbench
======================================

// Module: complex_accumulator
// PURPOSE
//   Downstream consumer of the complex multiplier. Sums a programmed number of packed complex products.
//   Each product carries a real and an imaginary half. The block returns a saturated complex sum as a dot-product result.
//   It uses a start/done handshake, with per-term valid/ready flow control on the product input.
// PARAMETERS
//   WIDTH      32  width of each product component; in_data is 2*WIDTH bits
//   ACC_WIDTH  40  width of each accumulator component; must be >= WIDTH
//   CNT_WIDTH  8   width of the term-count input
// PORTS
//   clk       in   1            rising-edge clock
//   rst       in   1            synchronous, active-high reset
//   start     in   1            begin a new accumulation; sampled only in IDLE
//   count     in   CNT_WIDTH    number of terms to sum; sampled together with start
//   in_valid  in   1            in_data carries a product term
//   in_data   in   2*WIDTH      [WIDTH-1:0] = signed real part; [2*WIDTH-1:WIDTH] = signed imaginary part
//   in_ready  out  1            block accepts a term this cycle
//   done      out  1            one-cycle pulse: result is final
//   overflow  out  1            sticky; set if any component saturated during the operation
//   result    out  2*ACC_WIDTH  [ACC_WIDTH-1:0] = real sum; [2*ACC_WIDTH-1:ACC_WIDTH] = imaginary sum
// BEHAVIOUR
//   Reset: state=IDLE; accumulators, result, done, overflow and in_ready are all 0.
//   The FSM has three states: IDLE, ACCUM and DONE.
//   - IDLE
//     - in_ready=0.
//     - On start with count!=0: clear both accumulators and overflow, load remaining=count, go to ACCUM.
//     - On start with count==0: clear the accumulators, result and overflow, go to DONE.
//   - ACCUM
//     - in_ready=1 combinationally (registered state only).
//     - A term is accepted when in_valid && in_ready. For each accepted term:
//       - sign-extend each component to ACC_WIDTH+1 bits and add it to its accumulator;
//       - clamp each sum to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1];
//       - if either component clamps, set overflow;
//       - decrement remaining.
//     - When the accepted term has remaining==1: register the clamped sums into result and go to DONE.
//     - With in_valid=0 nothing changes. Stalls of any length are legal.
//   - DONE
//     - done=1 for exactly this one cycle. Go to IDLE next cycle.
//   start is ignored in ACCUM and DONE; it is not queued.
//   Latency: done rises 1 cycle after the last term is accepted, and 1 cycle after a start with count==0.
//   Throughput: 1 term/cycle. An N-term operation occupies N+2 cycles minimum, start to next IDLE.
//   result and overflow stay stable from done until the next accepted start. They are not cleared by returning to IDLE.
//   Real and imaginary paths are fully independent: saturating one does not affect the other.
//   Once saturated, an accumulator keeps accumulating from the clamped value. Later opposite-sign terms can pull it back in range.
//   A sum that exactly reaches a bound is not an overflow.
//   Reset mid-operation aborts immediately: no done pulse, and result returns to 0.
//   in_data is ignored whenever in_ready=0.
// TESTING
//   All terms use default parameters unless a line states otherwise.
//   1. start, count=3; terms (3+4j), (-1+2j), (5-7j), one per cycle -> done 1 cycle after the 3rd term.
//      Required: result real=7, imag=-1 (0xFF_FFFF_FFFF), overflow=0.
//   2. Same as test 1 with in_valid dropped for 4 cycles between terms -> identical result.
//      Required: done delayed by exactly 4 cycles per gap; in_ready stays 1 throughout.
//   3. ACC_WIDTH=33; count=3; term 0x7FFFFFFF+0j three times.
//      Required: result real=0x0_FFFFFFFF (clamped to 2^32-1), overflow=1, imag=0.
//      Variant with count=2 -> result real=4294967294, overflow=0.
//   4. start with count=0 -> done on the next cycle; result=0, overflow=0; in_ready never asserts.
//   5. start pulsed during ACCUM and on the done cycle -> ignored; exactly one done per accepted start.
//   6. rst asserted after 2 of 5 terms are accepted -> no done; all outputs 0 on the next cycle.
//      Then a new count=1 term (-2-2j) -> result real=-2, imag=-2.

Source files
------------

// File: rtl/complex_accumulator.sv
// complex_accumulator: saturating dot-product accumulator for packed
// complex products, with a start/done handshake and valid/ready terms.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start, count  begin an operation of 'count' terms (sampled in IDLE)
//   in_valid      in_data carries a term {imag, real}
//   in_ready      a term is accepted this cycle (ACCUM state)
//   done          one-cycle pulse, result/overflow are final
//   overflow      sticky saturation flag for the current operation
//   result        {imag sum, real sum}, each ACC_WIDTH bits
module complex_accumulator #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 40,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_WIDTH-1:0]   count,
    input  logic                   in_valid,
    input  logic [2*WIDTH-1:0]     in_data,
    output logic                   in_ready,
    output logic                   done,
    output logic                   overflow,
    output logic [2*ACC_WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [ACC_WIDTH-1:0] acc_re, acc_im;
    logic [ACC_WIDTH-1:0] sat_re, sat_im;
    logic [ACC_WIDTH:0]   sum_re, sum_im;
    logic                 clip_re, clip_im;
    logic [CNT_WIDTH-1:0] remaining;
    logic                 accept, last;

    function automatic logic [ACC_WIDTH:0] sext(
        input logic [WIDTH-1:0] v
    );
        return {{(ACC_WIDTH+1-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    assign in_ready = (state == ACCUM);
    assign done     = (state == DONE);
    assign accept   = in_valid && in_ready;
    assign last     = (remaining == CNT_WIDTH'(1));

    // One guard bit makes the sum exact; it fits back into ACC_WIDTH
    // only when the guard bit equals the sign bit. Otherwise clamp
    // toward the guard bit's sign.
    always_comb begin
        sum_re  = {acc_re[ACC_WIDTH-1], acc_re} + sext(in_data[WIDTH-1:0]);
        sum_im  = {acc_im[ACC_WIDTH-1], acc_im}
                + sext(in_data[2*WIDTH-1:WIDTH]);
        clip_re = sum_re[ACC_WIDTH] ^ sum_re[ACC_WIDTH-1];
        clip_im = sum_im[ACC_WIDTH] ^ sum_im[ACC_WIDTH-1];
        sat_re  = clip_re
                ? {sum_re[ACC_WIDTH], {(ACC_WIDTH-1){~sum_re[ACC_WIDTH]}}}
                : sum_re[ACC_WIDTH-1:0];
        sat_im  = clip_im
                ? {sum_im[ACC_WIDTH], {(ACC_WIDTH-1){~sum_im[ACC_WIDTH]}}}
                : sum_im[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = (count == '0) ? DONE : ACCUM;
            end
            ACCUM: begin
                if (accept && last)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // result/overflow hold from done until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_re    <= '0;
            acc_im    <= '0;
            remaining <= '0;
            overflow  <= 1'b0;
            result    <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                acc_re    <= '0;
                acc_im    <= '0;
                overflow  <= 1'b0;
                remaining <= count;
                if (count == '0)
                    result <= '0;
            end
        end else if (state == ACCUM) begin
            if (accept) begin
                acc_re    <= sat_re;
                acc_im    <= sat_im;
                overflow  <= overflow | clip_re | clip_im;
                remaining <= remaining - CNT_WIDTH'(1);
                if (last)
                    result <= {sat_im, sat_re};
            end
        end
    end

endmodule

// File: tb/tb_complex_accumulator.sv
// tb_complex_accumulator: random and directed operations against a
// plain-arithmetic model, on a 40-bit and a 33-bit accumulator instance.
module tb_complex_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  count;
    logic        in_valid;
    logic [63:0] in_data;

    logic        rdy_a, done_a, ov_a;
    logic [79:0] res_a;
    logic        rdy_b, done_b, ov_b;
    logic [65:0] res_b;

    int checks   = 0;
    int failures = 0;

    int tr[256];
    int ti[256];

    longint er_a, ei_a, er_b, ei_b;
    bit     eo_a, eo_b;

    always #5 clk = ~clk;

    complex_accumulator dut_a (
        .clk(clk), .rst(rst), .start(start), .count(count),
        .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_a), .done(done_a), .overflow(ov_a),
        .result(res_a)
    );

    complex_accumulator #(.ACC_WIDTH(33)) dut_b (
        .clk(clk), .rst(rst), .start(start), .count(count),
        .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_b), .done(done_b), .overflow(ov_b),
        .result(res_b)
    );

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint clamp(input longint v, input int aw);
        longint mx, mn;
        mx = (longint'(1) <<< (aw - 1)) - 1;
        mn = -mx - 1;
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    task automatic model_add(inout longint s, inout bit ov,
                             input int t, input int aw);
        longint raw;
        raw = s + longint'(t);
        s = clamp(raw, aw);
        if (s != raw) ov = 1'b1;
    endtask

    task automatic check_final(input string tag);
        chk({tag, "_done_a"}, done_a, 1'b1);
        chk({tag, "_done_b"}, done_b, 1'b1);
        chk({tag, "_rdy_a"}, rdy_a, 1'b0);
        chk({tag, "_re_a"}, res_a[39:0], er_a[39:0]);
        chk({tag, "_im_a"}, res_a[79:40], ei_a[39:0]);
        chk({tag, "_ov_a"}, ov_a, eo_a);
        chk({tag, "_re_b"}, res_b[32:0], er_b[32:0]);
        chk({tag, "_im_b"}, res_b[65:33], ei_b[32:0]);
        chk({tag, "_ov_b"}, ov_b, eo_b);
    endtask

    // gap < 0: random stalls; otherwise a fixed stall between terms.
    task automatic run_op(input string tag, input int n, input int gap);
        int g;
        er_a = 0; ei_a = 0; er_b = 0; ei_b = 0;
        eo_a = 1'b0; eo_b = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_rdy"}, rdy_a, 1'b0);
        start    = 1'b1;
        count    = 8'(n);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (gap >= 0) g = (k == 0) ? 0 : gap;
            else g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            repeat (g) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
                start    = 1'($urandom_range(0, 1));
                count    = 8'($urandom);
                chk({tag, "_stall_rdy"}, rdy_a, 1'b1);
                chk({tag, "_stall_done"}, done_a, 1'b0);
                @(negedge clk);
            end
            start    = 1'($urandom_range(0, 1));
            count    = 8'($urandom);
            in_valid = 1'b1;
            in_data  = {32'(ti[k]), 32'(tr[k])};
            chk({tag, "_rdy_a"}, rdy_a, 1'b1);
            chk({tag, "_rdy_b"}, rdy_b, 1'b1);
            chk({tag, "_early_done"}, done_a | done_b, 1'b0);
            model_add(er_a, eo_a, tr[k], 40);
            model_add(ei_a, eo_a, ti[k], 40);
            model_add(er_b, eo_b, tr[k], 33);
            model_add(ei_b, eo_b, ti[k], 33);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        start    = 1'($urandom_range(0, 1));
        check_final(tag);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_one_done"}, done_a | done_b, 1'b0);
        chk({tag, "_back_idle"}, rdy_a | rdy_b, 1'b0);
    endtask

    function automatic int rnd_term();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 200)) - 100;
            1:       return 32'h7FFF_FFFF;
            2:       return int'(32'h8000_0000);
            default: return int'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; count = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", rdy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_ov", ov_a, 1'b0);
        chk("rst_res", res_a, 80'd0);
        rst = 1'b0;

        tr[0] = 3;  ti[0] = 4;
        tr[1] = -1; ti[1] = 2;
        tr[2] = 5;  ti[2] = -7;
        run_op("t1", 3, 0);
        chk("t1_re_const", res_a[39:0], 40'd7);
        chk("t1_im_const", res_a[79:40], 40'hFF_FFFF_FFFF);
        run_op("t2", 3, 4);
        chk("t2_re_const", res_a[39:0], 40'd7);

        for (int k = 0; k < 3; k++) begin
            tr[k] = 32'h7FFF_FFFF; ti[k] = 0;
        end
        run_op("t3", 3, 0);
        chk("t3_re_const", res_b[32:0], 33'h0_FFFF_FFFF);
        chk("t3_ov_const", ov_b, 1'b1);
        run_op("t3v", 2, 0);
        chk("t3v_re_const", res_b[32:0], 33'd4294967294);
        chk("t3v_ov_const", ov_b, 1'b0);

        tr[3] = -1; ti[3] = 0;
        run_op("recover", 4, 0);
        chk("recover_re", res_b[32:0], 33'h0_FFFF_FFFE);

        tr[0] = int'(32'h8000_0000); tr[1] = tr[0];
        ti[0] = 0; ti[1] = 0;
        run_op("minbound", 2, 0);
        chk("minbound_ov", ov_b, 1'b0);

        run_op("t4", 0, 0);
        chk("t4_res", res_a, 80'd0);

        for (int r = 0; r < 40; r++) begin
            int n;
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20)
                                             : $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                tr[k] = rnd_term();
                ti[k] = rnd_term();
            end
            run_op("rand", n, -1);
        end

        @(negedge clk);
        start = 1'b1; count = 8'd5;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = {32'h7FFF_FFFF, 32'h7FFF_FFFF};
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rdy", rdy_a | rdy_b, 1'b0);
        chk("t6_done", done_a | done_b, 1'b0);
        chk("t6_ov", ov_a | ov_b, 1'b0);
        chk("t6_res_a", res_a, 80'd0);
        chk("t6_res_b", res_b, 66'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_done", done_a | done_b, 1'b0);
        end
        tr[0] = -2; ti[0] = -2;
        run_op("t6b", 1, 0);
        chk("t6b_re", res_a[39:0], 40'hFF_FFFF_FFFE);
        chk("t6b_im", res_a[79:40], 40'hFF_FFFF_FFFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
